time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter TIMEOUT_TICKS, default 20: number of blinkTick pulses with no button activity after which an edit is abandoned.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 btnMode  input  1  single-cycle pulse, already debounced; advances the edit sequence.
REQ-005 btnUp  input  1  single-cycle pulse; increments the field being edited.
REQ-006 btnDown  input  1  single-cycle pulse; decrements the field being edited.
REQ-007 blinkTick  input  1  single-cycle pulse at about 2 Hz; drives blink phase and timeout.
REQ-008 rtcHour  input  8  BCD hour from the RTC reader; bits [7:6] are mode bits and are ignored.
REQ-009 rtcMin  input  8  BCD minute from the RTC reader.
REQ-010 wrAck  input  1  single-cycle pulse from the RTC writer; the write is complete.
REQ-011 dispHour  output  8  BCD hour to the FND controller.
REQ-012 dispMin  output  8  BCD minute to the FND controller.
REQ-013 blankHour  output  1  display blanks the hour digits when high.
REQ-014 blankMin  output  1  display blanks the minute digits when high.
REQ-015 wrReq  output  1  level request to the RTC writer.
REQ-016 wrHour  output  8  BCD hour to write; bit 7 is always 0 (24 h mode).
REQ-017 wrMin  output  8  BCD minute to write.
REQ-018 editing  output  1  high in any state other than RUN.

Function
REQ-019 The FSM states SHALL be RUN, EDIT_HOUR, EDIT_MIN and WRITE.
REQ-020 In RUN, dispHour SHALL be registered {2'b00, rtcHour[5:0]} and dispMin SHALL be registered rtcMin, both with 1-cycle latency.
REQ-021 In RUN, btnMode SHALL load the edit registers from rtcHour/rtcMin and enter EDIT_HOUR on the next cycle.
REQ-022 On that load, a field that is invalid (hour > 23, minute > 59, or any BCD digit > 9) SHALL be loaded as 8'h00.
REQ-023 In EDIT_HOUR, btnUp/btnDown SHALL step the hour by ±1 in BCD over 00..23 with wrap (23+1=00, 00-1=23).
REQ-024 In EDIT_MIN, btnUp/btnDown SHALL step the minute by ±1 in BCD over 00..59 with wrap (59+1=00, 00-1=59).
REQ-025 The minute SHALL NOT carry into or borrow from the hour.
REQ-026 In edit states, dispHour/dispMin SHALL show the edit registers, with 1-cycle latency.
REQ-027 btnMode SHALL advance EDIT_HOUR to EDIT_MIN, and EDIT_MIN to WRITE.
REQ-028 If btnUp and btnDown arrive in the same cycle, the edited value SHALL be unchanged.
REQ-029 If btnMode arrives in the same cycle as btnUp or btnDown, btnMode SHALL win and the value SHALL be unchanged.
REQ-030 The blink phase SHALL toggle on each blinkTick during edit states and SHALL be 0 whenever the state is RUN.
REQ-031 blankHour SHALL equal the blink phase in EDIT_HOUR, otherwise 0.
REQ-032 blankMin SHALL equal the blink phase in EDIT_MIN, otherwise 0.
REQ-033 The idle counter SHALL increment on each blinkTick in EDIT_HOUR/EDIT_MIN and SHALL clear on any button pulse or state change.
REQ-034 When the idle counter reaches TIMEOUT_TICKS, the FSM SHALL return to RUN without asserting wrReq.
REQ-035 Entering WRITE SHALL set wrReq=1 in the same cycle as the state change.
REQ-036 While wrReq=1, wrHour and wrMin SHALL hold the edited values stable.
REQ-037 In WRITE, wrReq SHALL stay high until wrAck; on wrAck, wrReq SHALL be 0 and the state RUN on the next cycle.
REQ-038 Buttons SHALL be ignored in WRITE, and WRITE has no timeout.
REQ-039 wrAck outside WRITE SHALL be ignored.

Reset
REQ-040 While rst=1, the state SHALL be RUN and all outputs, edit registers, blink phase and idle counter SHALL be 0.
REQ-041 Reset mid-edit or mid-write SHALL drop wrReq in the next cycle with no write issued.

Structure
REQ-042 The package SHALL hold the state enum and constants HOUR_MAX=8'h23 and MIN_MAX=8'h59.
REQ-043 Sub-module bcd_updown (2-digit BCD up/down with wrap, parameter MAX) SHALL be instantiated once for hour and once for minute.

Verification
REQ-044 Initial rtcHour=8'h12, rtcMin=8'h34; then mode, up, up, mode, down, mode; then wrAck after 3 cycles -> wrHour=8'h14, wrMin=8'h33, wrReq high exactly 3 cycles, then RUN.
REQ-045 EDIT_HOUR at 8'h23 plus up -> 8'h00; then down -> 8'h23; EDIT_MIN at 8'h00 plus down -> 8'h59; 8'h09 plus up -> 8'h10.
REQ-046 rtcHour=8'h2A, rtcMin=8'h7F, then mode -> edit registers load 8'h00/8'h00.
REQ-047 TIMEOUT_TICKS=3, in EDIT_MIN, three blinkTick with no button -> RUN, wrReq never asserted; a button before the 3rd tick restarts the count.
REQ-048 btnUp and btnDown in the same cycle -> value unchanged; btnMode with btnUp in the same cycle -> state advances, value unchanged.
REQ-049 rst pulse while in WRITE with wrReq=1 -> wrReq=0, editing=0, blank outputs=0 on the next cycle.

Source files
------------

// File: rtl/time_set_ctrl_pkg.sv
// Shared types and constants for the time-set controller.
// No logic; state enum, BCD limits and a load-sanitising helper.
// No flow control.
package time_set_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    EDIT_HOUR = 2'd1,
    EDIT_MIN  = 2'd2,
    WRITE     = 2'd3
  } state_t;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;

  // A field read from the RTC that is not a legal 2-digit BCD value in
  // range starts the edit from zero instead.
  function automatic logic [7:0] bcd_load(input logic [7:0] v, input logic [7:0] max);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > max) begin
      return 8'h00;
    end
    return v;
  endfunction

endpackage

// File: rtl/time_set_ctrl_bcd_updown.sv
// Two-digit BCD +/-1 step with wrap over 00..MAX.
// Combinational, zero latency.
// No flow control; up and down together leave the value unchanged.
module bcd_updown
  import time_set_ctrl_pkg::*;
#(
  parameter logic [7:0] MAX = MIN_MAX
) (
  input  logic [7:0] val,
  input  logic       up,
  input  logic       down,
  output logic [7:0] nxt
);

  // Step the ones digit, rippling into the tens digit, wrapping at the ends.
  always_comb begin
    nxt = val;
    if (up && !down) begin
      if (val >= MAX) begin
        nxt = 8'h00;
      end else if (val[3:0] == 4'd9) begin
        nxt = {val[7:4] + 4'd1, 4'd0};
      end else begin
        nxt = {val[7:4], val[3:0] + 4'd1};
      end
    end else if (down && !up) begin
      if (val == 8'h00) begin
        nxt = MAX;
      end else if (val[3:0] == 4'd0) begin
        nxt = {val[7:4] - 4'd1, 4'd9};
      end else begin
        nxt = {val[7:4], val[3:0] - 4'd1};
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven hour/minute editor in front of an RTC, with blink and timeout.
// Display path 1 cycle; wrReq rises in the cycle WRITE is entered.
// wrReq is a level held until wrAck; buttons are ignored while writing.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnMode,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       blinkTick,
  input  logic [7:0] rtcHour,
  input  logic [7:0] rtcMin,
  input  logic       wrAck,
  output logic [7:0] dispHour,
  output logic [7:0] dispMin,
  output logic       blankHour,
  output logic       blankMin,
  output logic       wrReq,
  output logic [7:0] wrHour,
  output logic [7:0] wrMin,
  output logic       editing
);

  localparam int CW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(TIMEOUT_TICKS - 1);

  state_t        state, next_state;
  logic [7:0]    edit_hour, edit_min;
  logic [7:0]    hour_step, min_step;
  logic [7:0]    rtc_hour_bcd;
  logic [CW-1:0] idle_cnt;
  logic          phase;
  logic          in_edit, any_btn, timeout;

  // Mode bits in the top of the RTC hour byte are not part of the value.
  assign rtc_hour_bcd = rtcHour & 8'h3F;
  assign in_edit      = (state == EDIT_HOUR) || (state == EDIT_MIN);
  assign any_btn      = btnMode || btnUp || btnDown;
  assign timeout      = blinkTick && !any_btn && (idle_cnt == LAST_TICK);

  bcd_updown #(.MAX(HOUR_MAX)) u_hour (
    .val  (edit_hour),
    .up   (btnUp),
    .down (btnDown),
    .nxt  (hour_step)
  );

  bcd_updown #(.MAX(MIN_MAX)) u_min (
    .val  (edit_min),
    .up   (btnUp),
    .down (btnDown),
    .nxt  (min_step)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  // Next state: mode advances, idle timeout abandons, ack finishes the write.
  always_comb begin
    next_state = state;
    case (state)
      RUN:       if (btnMode) next_state = EDIT_HOUR;
      EDIT_HOUR: if (btnMode) next_state = EDIT_MIN;
                 else if (timeout) next_state = RUN;
      EDIT_MIN:  if (btnMode) next_state = WRITE;
                 else if (timeout) next_state = RUN;
      WRITE:     if (wrAck) next_state = RUN;
      default:   next_state = RUN;
    endcase
  end

  // State-decoded outputs; the write payload is the edit registers directly.
  always_comb begin
    editing   = (state != RUN);
    wrReq     = (state == WRITE);
    blankHour = (state == EDIT_HOUR) && phase;
    blankMin  = (state == EDIT_MIN) && phase;
    wrHour    = edit_hour & 8'h7F;
    wrMin     = edit_min;
  end

  // Edit registers: load from the RTC on entry, step while their field is active.
  always_ff @(posedge clk) begin
    if (rst) begin
      edit_hour <= 8'h00;
      edit_min  <= 8'h00;
    end else begin
      case (state)
        RUN: if (btnMode) begin
          edit_hour <= bcd_load(rtc_hour_bcd, HOUR_MAX);
          edit_min  <= bcd_load(rtcMin, MIN_MAX);
        end
        EDIT_HOUR: if (!btnMode) edit_hour <= hour_step;
        EDIT_MIN:  if (!btnMode) edit_min  <= min_step;
        default: ;
      endcase
    end
  end

  // Idle counter: counts blink ticks with no button activity in an edit state.
  always_ff @(posedge clk) begin
    if (rst || !in_edit || any_btn || (next_state != state)) idle_cnt <= '0;
    else if (blinkTick) idle_cnt <= idle_cnt + CW'(1);
  end

  // Blink phase: toggles on ticks while editing, forced low whenever RUN is next.
  always_ff @(posedge clk) begin
    if (rst || next_state == RUN) phase <= 1'b0;
    else if (in_edit && blinkTick) phase <= ~phase;
  end

  // Display registers: live RTC time in RUN, edit registers otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      dispHour <= 8'h00;
      dispMin  <= 8'h00;
    end else if (state == RUN) begin
      dispHour <= rtc_hour_bcd;
      dispMin  <= rtcMin;
    end else begin
      dispHour <= edit_hour;
      dispMin  <= edit_min;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomized and directed bench for time_set_ctrl against an integer-time model.
// Model advances on each rising edge; outputs compared on every falling edge.
// wrAck is driven freely; the design must ignore it outside a write.
module tb_time_set_ctrl;

  localparam int TO = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btnMode = 1'b0, btnUp = 1'b0, btnDown = 1'b0, blinkTick = 1'b0, wrAck = 1'b0;
  logic [7:0] rtcHour = 8'h12, rtcMin = 8'h34;
  logic [7:0] dispHour, dispMin, wrHour, wrMin;
  logic       blankHour, blankMin, wrReq, editing;

  always #5 clk = ~clk;

  time_set_ctrl #(.TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .rst(rst), .btnMode(btnMode), .btnUp(btnUp), .btnDown(btnDown),
    .blinkTick(blinkTick), .rtcHour(rtcHour), .rtcMin(rtcMin), .wrAck(wrAck),
    .dispHour(dispHour), .dispMin(dispMin), .blankHour(blankHour), .blankMin(blankMin),
    .wrReq(wrReq), .wrHour(wrHour), .wrMin(wrMin), .editing(editing)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  bit wr_seen = 1'b0;

  // Model state: mode 0 idle, 1 hour, 2 minute, 3 writing; times as integers.
  int         m_mode = 0;
  int         m_h = 0, m_m = 0, m_idle = 0;
  bit         m_phase = 1'b0;
  logic [7:0] m_dh = 8'h00, m_dm = 8'h00;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int from_rtc(input logic [7:0] v, input int max);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9 || lo > 9 || hi * 10 + lo > max) return 0;
    return hi * 10 + lo;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int nm;
    if (rst) begin
      m_mode = 0; m_h = 0; m_m = 0; m_idle = 0; m_phase = 0;
      m_dh = 8'h00; m_dm = 8'h00;
    end else begin
      if (m_mode == 0) begin
        m_dh = rtcHour & 8'h3F;
        m_dm = rtcMin;
      end else begin
        m_dh = to_bcd(m_h);
        m_dm = to_bcd(m_m);
      end
      case (m_mode)
        0: if (btnMode) begin
          m_h = from_rtc(rtcHour & 8'h3F, 23);
          m_m = from_rtc(rtcMin, 59);
          m_mode = 1;
        end
        1, 2: begin
          nm = m_mode;
          if (btnMode) begin
            nm = m_mode + 1;
            m_idle = 0;
          end else if (btnUp || btnDown) begin
            if (btnUp != btnDown) begin
              if (m_mode == 1) m_h = btnUp ? (m_h + 1) % 24 : (m_h + 23) % 24;
              else             m_m = btnUp ? (m_m + 1) % 60 : (m_m + 59) % 60;
            end
            m_idle = 0;
          end else if (blinkTick) begin
            m_idle++;
            if (m_idle == TO) nm = 0;
          end
          if (blinkTick) m_phase = !m_phase;
          if (nm == 0) begin
            m_phase = 0;
            m_idle = 0;
          end
          m_mode = nm;
        end
        default: if (wrAck) begin
          m_mode = 0;
          m_phase = 0;
        end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dispHour", dispHour, m_dh);
      chk("dispMin", dispMin, m_dm);
      chk("blankHour", blankHour, (m_mode == 1) && m_phase);
      chk("blankMin", blankMin, (m_mode == 2) && m_phase);
      chk("wrReq", wrReq, m_mode == 3);
      chk("wrHour", wrHour, to_bcd(m_h));
      chk("wrMin", wrMin, to_bcd(m_m));
      chk("editing", editing, m_mode != 0);
    end
    if (wrReq === 1'b1) wr_seen = 1'b1;
  end

  task automatic drive(input bit md, input bit up, input bit dn, input bit tk, input bit ak);
    @(negedge clk);
    btnMode = md; btnUp = up; btnDown = dn; blinkTick = tk; wrAck = ak;
  endtask

  initial begin
    int wr_cycles;
    logic [7:0] hb;

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_dispHour", dispHour, 8'h00);
    chk("rst_wrReq", wrReq, 1'b0);
    chk("rst_editing", editing, 1'b0);
    rst = 1'b0;

    // 12:34 -> hour +2, minute -1 -> write 14:33, ack on the third request cycle.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0);
    wr_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, i == 2);
      if (i == 0) begin
        chk("seq_wrHour", wrHour, 8'h14);
        chk("seq_wrMin", wrMin, 8'h33);
        chk("model_hour", to_bcd(m_h), 8'h14);
      end
      if (wrReq) wr_cycles++;
    end
    chk("seq_wrReq_cycles", wr_cycles, 3);
    chk("seq_back_to_run", editing, 1'b0);

    // Wrap boundaries.
    rtcHour = 8'h23; rtcMin = 8'h00;
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("hour_23_up", wrHour, 8'h00);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("hour_00_down", wrHour, 8'h23);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("min_00_down", wrMin, 8'h59);
    chk("min_no_borrow", wrHour, 8'h23);
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("min_to_09", wrMin, 8'h09);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("min_09_up", wrMin, 8'h10);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);

    // Invalid RTC fields load as zero.
    rtcHour = 8'h2A; rtcMin = 8'h7F;
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("bad_hour_load", wrHour, 8'h00);
    chk("bad_min_load", wrMin, 8'h00);

    // Simultaneous buttons.
    drive(0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("up_down_same", wrHour, 8'h00);
    drive(1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("mode_up_hour", wrHour, 8'h00);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("mode_up_advanced", wrMin, 8'h01);

    // Timeout in minute edit, restarted by a button before the third tick.
    wr_seen = 1'b0;
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    chk("timeout_restart", editing, 1'b1);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    chk("timeout_run", editing, 1'b0);
    chk("timeout_no_write", wr_seen, 1'b0);

    // Reset during a write.
    rtcHour = 8'h10; rtcMin = 8'h20;
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("write_pending", wrReq, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_write_wrReq", wrReq, 1'b0);
    chk("rst_write_editing", editing, 1'b0);
    chk("rst_write_blank", {blankHour, blankMin}, 2'b00);

    // Random traffic.
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 299) == 0);
      btnMode   = ($urandom_range(0, 7) == 0);
      btnUp     = ($urandom_range(0, 3) == 0);
      btnDown   = ($urandom_range(0, 3) == 0);
      blinkTick = ($urandom_range(0, 4) == 0);
      wrAck     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 3) != 0) begin
          hb = to_bcd($urandom_range(0, 23));
          rtcHour = {2'($urandom), hb[5:0]};
          rtcMin  = to_bcd($urandom_range(0, 59));
        end else begin
          rtcHour = 8'($urandom);
          rtcMin  = 8'($urandom);
        end
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
